pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipelined LEGv8 CPU, instantiated beside controller and datapath in the cpu top level.
- Detects load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Drives per-stage pipeline-register enables plus bubble and flush controls.
- Runs a watchdog on memory waits and halts the pipeline on timeout.

---
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the hazard-detection inputs and the stall/flush controls that
//   pass between the LEGv8 pipeline (master) and pipeline_hazard_ctrl (slave).
//
//   Signals (from the slave's view):
//     in : id_rn, id_rm, id_uses_rn, id_uses_rm  - ID-stage source operands
//          ex_memrd, ex_rd                       - EX-stage load and destination
//          br_taken                              - branch resolved taken in ID
//          mem_req, mem_ready                    - data-memory handshake
//     out: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en - stage enables
//          if_id_flush, id_ex_bubble             - NOP / zeroed-control inject
//          mem_err                               - sticky watchdog timeout
//          stall_cycles, flush_count             - performance counters
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic             ex_memrd;
  logic [4:0]       ex_rd;
  logic             br_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_memrd, ex_rd,
           br_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_bubble, mem_err, stall_cycles, flush_count
  );

  modport master (
    output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_memrd, ex_rd,
           br_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_bubble, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage LEGv8 pipeline. Detects
//   load-use hazards, taken-branch flushes and data-memory waits, and drives
//   the per-stage register enables plus the IF/ID flush and ID/EX bubble.
//   A watchdog halts the pipeline (sticky mem_err) if a memory access stays
//   outstanding for TIMEOUT frozen cycles; TIMEOUT=0 disables it.
//
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-high reset (forces all controls to 0)
//     hz    - pipeline_hazard_ctrl_if.slave (hazard inputs, stage controls,
//             mem_err, performance counters)
//
//   Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
//   stall_cycles / flush_count counters; otherwise both read as 0.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  // One spare bit above what TIMEOUT needs so the saturating count can
  // always reach the threshold.
  localparam int unsigned          WAIT_W    = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0]    WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0]    TIMEOUT_C = WAIT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q,  wait_d;
  logic                err_q,   err_d;
  logic [WAIT_W-1:0]   wait_inc;

  logic load_use;
  logic mem_stall;
  logic issue;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_bubble;

  // XZR (X31) is never a real destination, so it cannot create a hazard.
  assign load_use = hz.ex_memrd && (hz.ex_rd != 5'd31) &&
                    ((hz.id_uses_rn && (hz.id_rn == hz.ex_rd)) ||
                     (hz.id_uses_rm && (hz.id_rm == hz.ex_rd)));

  assign mem_stall = hz.mem_req && !hz.mem_ready;

  assign wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    issue        = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          // First frozen cycle of this access counts toward the watchdog.
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
          if (TIMEOUT == 1) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end else begin
          issue = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_ready) begin
          wait_d = wait_inc;
          if ((TIMEOUT != 0) && (wait_inc >= TIMEOUT_C)) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end else begin
          issue   = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end
      end
      HALT: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    // Non-frozen cycle: load-use outranks a taken branch, which re-resolves
    // next cycle once the load data can be forwarded.
    if (issue) begin
      if (load_use) begin
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = hz.br_taken;
      end
    end

    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.mem_wb_en    = mem_wb_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.mem_err      = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    if (if_id_flush && (flush_q != '1)) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif

endmodule
